// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: flow ops and FSM states.
package pc_seq_pkg;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_RETI = 3'd7;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;
endpackage

// File: rtl/pc_sequencer_call_stack.sv
// Return-address stack: DEPTH entries, guarded push/pop, combinational top-of-stack read.
module call_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_SP = (AW+1)'(DEPTH);

  logic [AW:0]     sp;
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_idx;

  assign full   = (sp == FULL_SP);
  assign empty  = (sp == '0);
  // sp==DEPTH wraps the low bits to 0, so sp-1 on the low bits still hits the top entry
  assign rd_idx = sp[AW-1:0] - AW'(1);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               sp <= '0;
    else if (push && !full)  sp <= sp + (AW+1)'(1);
    else if (pop && !empty)  sp <= sp - (AW+1)'(1);
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC mux, call stack, RUN/HALTED/FAULT FSM.
// Optional vectored interrupt enabled by defining PC_SEQ_IRQ_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              DEPTH      = 8,
  parameter logic [PC_W-1:0] IRQ_VECTOR = 10'h3F0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            halted,
  output logic            fault
`ifdef PC_SEQ_IRQ_EN
  ,
  input  logic            irq,
  output logic            irq_ack
`endif
);
  logic [1:0]      state, state_n;
  logic [PC_W-1:0] pc_n, pc_inc, s_din, s_dout;
  logic            push, pop, run;

  call_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(s_din), .dout(s_dout), .full(stack_full), .empty(stack_empty)
  );

  assign pc_inc = pc + PC_W'(1);
  assign run    = en && (state == ST_RUN);
  assign halted = (state == ST_HALTED);
  assign fault  = (state == ST_FAULT);

`ifdef PC_SEQ_IRQ_EN
  logic mask, mask_n, take;
`else
  logic unused_irq_vector;
  assign unused_irq_vector = ^IRQ_VECTOR;
`endif

  always_comb begin
    pc_n    = pc;
    state_n = state;
    push    = 1'b0;
    pop     = 1'b0;
    s_din   = pc_inc;
`ifdef PC_SEQ_IRQ_EN
    mask_n  = mask;
    take    = 1'b0;
`endif
    if (run) begin
`ifdef PC_SEQ_IRQ_EN
      // interrupt entry discards op; saved pc re-executes on return
      if (irq && !mask) begin
        if (stack_full) state_n = ST_FAULT;
        else begin
          push   = 1'b1;
          s_din  = pc;
          pc_n   = IRQ_VECTOR;
          mask_n = 1'b1;
          take   = 1'b1;
        end
      end else
`endif
      begin
        case (op)
          OP_JMP:  pc_n = target;
          OP_JZ:   pc_n = zero ? target : pc_inc;
          OP_JNZ:  pc_n = zero ? pc_inc : target;
          OP_CALL:
            if (stack_full) state_n = ST_FAULT;
            else begin push = 1'b1; pc_n = target; end
          OP_RET:
            if (stack_empty) state_n = ST_FAULT;
            else begin pop = 1'b1; pc_n = s_dout; end
          OP_HALT: state_n = ST_HALTED;
`ifdef PC_SEQ_IRQ_EN
          OP_RETI:
            if (stack_empty) state_n = ST_FAULT;
            else begin pop = 1'b1; pc_n = s_dout; mask_n = 1'b0; end
`endif
          default: pc_n = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask    <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      mask    <= mask_n;
      irq_ack <= take;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus multi-cycle corner sequences.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = OP_NEXT;
  logic [9:0] target = '0;
  logic       zero = 1'b0;
  logic [9:0] pc;
  logic       stack_empty, stack_full, halted, fault;
  logic       irq = 1'b0;
  logic       irq_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target), .zero(zero),
    .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full),
    .halted(halted), .fault(fault)
`ifdef PC_SEQ_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );
`ifndef PC_SEQ_IRQ_EN
  assign irq_ack = 1'b0;
`endif

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic [9:0] target;
    logic       zero;
    logic [9:0] pc;
    logic       empty, full, hlt, flt;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic e, logic [2:0] o, logic [9:0] t, logic z,
                              logic [9:0] p, logic em, logic fu, logic h, logic f);
    vec_t v;
    v.en = e; v.op = o; v.target = t; v.zero = z;
    v.pc = p; v.empty = em; v.full = fu; v.hlt = h; v.flt = f;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(logic e, logic [2:0] o, logic [9:0] t, logic z);
    en = e; op = o; target = t; zero = z;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; irq = 1'b0; op = OP_NEXT;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int k;
    logic [9:0] exp_ret;

    tbl[0]  = mk(1, OP_NEXT, 10'h000, 0, 10'h001, 1, 0, 0, 0);
    tbl[1]  = mk(1, OP_NEXT, 10'h000, 0, 10'h002, 1, 0, 0, 0);
    tbl[2]  = mk(1, OP_NEXT, 10'h000, 0, 10'h003, 1, 0, 0, 0);
    tbl[3]  = mk(1, OP_JMP,  10'h005, 0, 10'h005, 1, 0, 0, 0);
    tbl[4]  = mk(1, OP_CALL, 10'h040, 0, 10'h040, 0, 0, 0, 0);
    tbl[5]  = mk(1, OP_RET,  10'h000, 0, 10'h006, 1, 0, 0, 0);
    tbl[6]  = mk(1, OP_JZ,   10'h020, 1, 10'h020, 1, 0, 0, 0);
    tbl[7]  = mk(1, OP_JZ,   10'h020, 0, 10'h021, 1, 0, 0, 0);
    tbl[8]  = mk(1, OP_JNZ,  10'h030, 1, 10'h022, 1, 0, 0, 0);
    tbl[9]  = mk(1, OP_JNZ,  10'h030, 0, 10'h030, 1, 0, 0, 0);
    tbl[10] = mk(0, OP_JMP,  10'h100, 0, 10'h030, 1, 0, 0, 0);
    tbl[11] = mk(0, OP_CALL, 10'h100, 0, 10'h030, 1, 0, 0, 0);
    tbl[12] = mk(1, OP_JMP,  10'h3FF, 0, 10'h3FF, 1, 0, 0, 0);
    tbl[13] = mk(1, OP_NEXT, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    tbl[14] = mk(1, OP_JMP,  10'h3FF, 0, 10'h3FF, 1, 0, 0, 0);
    tbl[15] = mk(1, OP_CALL, 10'h080, 0, 10'h080, 0, 0, 0, 0);
    tbl[16] = mk(1, OP_RET,  10'h000, 0, 10'h000, 1, 0, 0, 0);
    tbl[17] = mk(1, OP_JMP,  10'h123, 0, 10'h123, 1, 0, 0, 0);
    tbl[18] = mk(1, OP_HALT, 10'h000, 0, 10'h123, 1, 0, 1, 0);
    tbl[19] = mk(1, OP_JMP,  10'h055, 0, 10'h123, 1, 0, 1, 0);
    tbl[20] = mk(1, OP_NEXT, 10'h000, 0, 10'h123, 1, 0, 1, 0);
    tbl[21] = mk(1, OP_CALL, 10'h200, 0, 10'h123, 1, 0, 1, 0);
    tbl[22] = mk(1, OP_RET,  10'h000, 0, 10'h123, 1, 0, 1, 0);
    tbl[23] = mk(1, OP_JZ,   10'h066, 1, 10'h123, 1, 0, 1, 0);

    #1;
    chk("reset_pc", pc, 0);
    chk("reset_empty", stack_empty, 1);
    chk("reset_full", stack_full, 0);
    chk("reset_halted", halted, 0);
    chk("reset_fault", fault, 0);
    chk("reset_ack", irq_ack, 0);
    do_reset();

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].en, tbl[i].op, tbl[i].target, tbl[i].zero);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_empty", i), stack_empty, tbl[i].empty);
      chk($sformatf("vec%0d_full", i), stack_full, tbl[i].full);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].hlt);
      chk($sformatf("vec%0d_fault", i), fault, tbl[i].flt);
    end

    // asynchronous reset between edges
    do_reset();
    step(1, OP_NEXT, 0, 0);
    step(1, OP_CALL, 10'h040, 0);
    chk("pre_async_empty", stack_empty, 0);
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 0);
    chk("async_empty", stack_empty, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 8 nested calls, unwind, then underflow
    for (int i = 0; i < 8; i++) begin
      step(1, OP_CALL, 10'h100 + 10'(i), 0);
      chk($sformatf("call%0d_full", i), stack_full, (i == 7) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      k = 7 - i;
      exp_ret = (k == 0) ? 10'h001 : 10'h100 + 10'(k);
      step(1, OP_RET, 0, 0);
      chk($sformatf("ret%0d_pc", i), pc, exp_ret);
    end
    chk("unwind_empty", stack_empty, 1);
    step(1, OP_RET, 0, 0);
    chk("uflow_fault", fault, 1);
    chk("uflow_pc", pc, 1);

    // overflow on the 9th call, then everything ignored
    do_reset();
    for (int i = 0; i < 8; i++) step(1, OP_CALL, 10'h100 + 10'(i), 0);
    step(1, OP_CALL, 10'h200, 0);
    chk("oflow_fault", fault, 1);
    chk("oflow_pc", pc, 10'h107);
    chk("oflow_full", stack_full, 1);
    step(1, OP_JMP, 10'h077, 0);
    chk("oflow_hold_pc", pc, 10'h107);
    step(1, OP_RET, 0, 0);
    chk("oflow_hold_ret", pc, 10'h107);
    chk("oflow_hold_full", stack_full, 1);

    // underflow straight out of reset
    do_reset();
    step(1, OP_RET, 0, 0);
    chk("rst_ret_fault", fault, 1);
    chk("rst_ret_pc", pc, 0);
    chk("rst_ret_halted", halted, 0);

    // CALL at 0x3FF pushes the wrapped return address
    do_reset();
    step(1, OP_JMP, 10'h3FF, 0);
    step(1, OP_CALL, 10'h050, 0);
    step(1, OP_RET, 0, 0);
    chk("wrap_call_ret", pc, 10'h000);

`ifdef PC_SEQ_IRQ_EN
    do_reset();
    step(1, OP_JMP, 10'h010, 0);
    irq = 1'b1;
    step(0, OP_JMP, 10'h099, 0);
    chk("irq_en0_pc", pc, 10'h010);
    chk("irq_en0_ack", irq_ack, 0);
    step(1, OP_JMP, 10'h099, 0);
    chk("irq_entry_pc", pc, 10'h3F0);
    chk("irq_entry_ack", irq_ack, 1);
    chk("irq_entry_empty", stack_empty, 0);
    step(1, OP_NEXT, 0, 0);
    chk("irq_masked_pc", pc, 10'h3F1);
    chk("irq_ack_pulse", irq_ack, 0);
    step(1, OP_RETI, 0, 0);
    chk("reti_pc", pc, 10'h010);
    chk("reti_ack", irq_ack, 0);
    step(1, OP_NEXT, 0, 0);
    chk("irq_again_pc", pc, 10'h3F0);
    chk("irq_again_ack", irq_ack, 1);
    irq = 1'b0;
    step(1, OP_RET, 0, 0);
    chk("ret_keeps_mask_pc", pc, 10'h010);
    irq = 1'b1;
    step(1, OP_NEXT, 0, 0);
    chk("ret_keeps_mask_next", pc, 10'h011);
    chk("ret_keeps_mask_ack", irq_ack, 0);
    irq = 1'b0;

    do_reset();
    for (int i = 0; i < 8; i++) step(1, OP_CALL, 10'h100 + 10'(i), 0);
    irq = 1'b1;
    step(1, OP_NEXT, 0, 0);
    chk("irq_oflow_fault", fault, 1);
    chk("irq_oflow_ack", irq_ack, 0);
    chk("irq_oflow_pc", pc, 10'h107);
    irq = 1'b0;

    do_reset();
    step(1, OP_RETI, 0, 0);
    chk("reti_uflow_fault", fault, 1);
`else
    do_reset();
    step(1, OP_RETI, 0, 0);
    chk("op7_next_pc", pc, 1);
    chk("op7_next_fault", fault, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
